// File: rtl/cordic_pkg.sv
// CORDIC shared definitions: mode codes, arctangent table, gain constant and stage control payload.
package cordic_pkg;

  localparam int unsigned TAB_FRAC = 30;
  localparam int unsigned TAB_LEN  = 32;

  typedef enum logic [1:0] {
    MODE_COS  = 2'd0,
    MODE_SIN  = 2'd1,
    MODE_BOTH = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  // Control fields that ride alongside the x/y/z datapath through every stage.
  typedef struct packed {
    logic  valid;
    mode_e mode;
    logic  clamp;
  } stage_ctl_t;

  // CORDIC gain 1/prod(sqrt(1+2^-2i)), Q2.30.
  localparam logic [31:0] CORDIC_K_Q30 = 32'd652032874;

  // atan(2^-i), Q2.30.
  localparam logic [31:0] ATAN_TAB [TAB_LEN] = '{
    32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
    32'd67021687,  32'd33543516,  32'd16775851,  32'd8388437,
    32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
    32'd262144,    32'd131072,    32'd65536,     32'd32768,
    32'd16384,     32'd8192,      32'd4096,      32'd2048,
    32'd1024,      32'd512,       32'd256,       32'd128,
    32'd64,        32'd32,        32'd16,        32'd8,
    32'd4,         32'd2,         32'd1,         32'd0
  };

  // Rescale a Q2.30 constant to fbits fractional bits, rounding half up.
  function automatic logic [31:0] scale_q30(input logic [31:0] v, input int unsigned fbits);
    logic [32:0]  sum;
    int unsigned  sh;
    sum = '0;
    sh  = 0;
    if (fbits >= TAB_FRAC) begin
      return v << (fbits - TAB_FRAC);
    end
    sh  = TAB_FRAC - fbits;
    sum = {1'b0, v} + (33'd1 << (sh - 1));
    return 32'(sum >> sh);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC pipeline stage: UNROLL micro-rotations starting at index BASE, then a register.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned GUARD  = 2,
  parameter int unsigned BASE   = 0,
  parameter int unsigned UNROLL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  stage_ctl_t                  ctl_i,
  input  logic signed [WIDTH+GUARD:0] x_i,
  input  logic signed [WIDTH+GUARD:0] y_i,
  input  logic signed [WIDTH+GUARD:0] z_i,
  input  logic signed [WIDTH-1:0]     angle_i,
  output stage_ctl_t                  ctl_o,
  output logic signed [WIDTH+GUARD:0] x_o,
  output logic signed [WIDTH+GUARD:0] y_o,
  output logic signed [WIDTH+GUARD:0] z_o,
  output logic signed [WIDTH-1:0]     angle_o
);
  localparam int unsigned IW   = WIDTH + GUARD + 1;
  localparam int unsigned FRAC = WIDTH - 2 + GUARD;

  stage_ctl_t              ctl_d, ctl_q;
  logic signed [IW-1:0]    x_d, x_q, y_d, y_q, z_d, z_q;
  logic signed [WIDTH-1:0] angle_d, angle_q;
  logic signed [IW-1:0]    x_t, a_t;

  // Micro-rotations: steer towards z = 0, rotating (x, y) by +/- atan(2^-i).
  always_comb begin
    ctl_d   = ctl_i;
    angle_d = angle_i;
    x_d     = x_i;
    y_d     = y_i;
    z_d     = z_i;
    x_t     = '0;
    a_t     = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      x_t = x_d;
      a_t = IW'(scale_q30(ATAN_TAB[5'(BASE + u)], FRAC));
      if (!z_d[IW-1]) begin
        x_d = x_d - (y_d >>> (BASE + u));
        y_d = y_d + (x_t >>> (BASE + u));
        z_d = z_d - a_t;
      end else begin
        x_d = x_d + (y_d >>> (BASE + u));
        y_d = y_d - (x_t >>> (BASE + u));
        z_d = z_d + a_t;
      end
    end
  end

  // Stage register; frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      angle_q <= '0;
    end else if (clk_en) begin
      ctl_q   <= ctl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      angle_q <= angle_d;
    end
  end

  assign ctl_o   = ctl_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign angle_o = angle_q;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC cos/sin core with input clamping, per-operation mode and clk_en stall.
module cordic_sincos_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned ITER   = 20,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned GUARD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] x_one,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_aux,
  output logic             clamped,
  output logic             done
);
  localparam int unsigned S    = ITER / UNROLL;
  localparam int unsigned IW   = WIDTH + GUARD + 1;
  localparam int unsigned TW   = IW + 1;
  localparam int unsigned FRAC = WIDTH - 2 + GUARD;

  localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(1) << (WIDTH - 2);
  localparam logic signed [TW-1:0]    ONE_T = TW'(1) << (WIDTH - 2);
  localparam logic signed [TW-1:0]    HALF  = TW'((1 << GUARD) >> 1);
  localparam logic signed [IW-1:0]    K0    = IW'(scale_q30(CORDIC_K_Q30, FRAC));

  logic signed [WIDTH-1:0] x_in, ang_c;
  logic                    clamp_c;

  stage_ctl_t              ctl_s [S+1];
  logic signed [IW-1:0]    x_s   [S+1];
  logic signed [IW-1:0]    y_s   [S+1];
  logic signed [IW-1:0]    z_s   [S+1];
  logic signed [WIDTH-1:0] ang_s [S+1];

  logic [WIDTH-1:0] result_d, result_q, result_aux_d, result_aux_q;
  logic             clamped_d, clamped_q, done_d, done_q;

  assign x_in = x_one;

  // Limit the incoming angle to [-1.0, +1.0] and flag when it had to be limited.
  always_comb begin
    ang_c   = x_in;
    clamp_c = 1'b0;
    if (x_in > ONE) begin
      ang_c   = ONE;
      clamp_c = 1'b1;
    end else if (x_in < -ONE) begin
      ang_c   = -ONE;
      clamp_c = 1'b1;
    end
  end

  // Initial vector (K, 0) at angle z0; the first stage register captures it.
  assign ctl_s[0] = '{valid: start, mode: mode_e'(n), clamp: clamp_c};
  assign x_s[0]   = K0;
  assign y_s[0]   = '0;
  assign z_s[0]   = IW'(ang_c) <<< GUARD;
  assign ang_s[0] = ang_c;

  for (genvar g = 0; g < S; g++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .GUARD (GUARD),
      .BASE  (g * UNROLL),
      .UNROLL(UNROLL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .ctl_i  (ctl_s[g]),
      .x_i    (x_s[g]),
      .y_i    (y_s[g]),
      .z_i    (z_s[g]),
      .angle_i(ang_s[g]),
      .ctl_o  (ctl_s[g+1]),
      .x_o    (x_s[g+1]),
      .y_o    (y_s[g+1]),
      .z_o    (z_s[g+1]),
      .angle_o(ang_s[g+1])
    );
  end

  // Drop the guard bits with round-half-up, then saturate to [-1.0, +1.0].
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [TW-1:0] t;
    t = TW'(v) + HALF;
    t = t >>> GUARD;
    if (t > ONE_T) begin
      t = ONE_T;
    end else if (t < -ONE_T) begin
      t = -ONE_T;
    end
    return WIDTH'(t);
  endfunction

  // Select outputs by mode; everything reads zero when no operation completes.
  always_comb begin
    done_d       = ctl_s[S].valid;
    clamped_d    = 1'b0;
    result_d     = '0;
    result_aux_d = '0;
    if (ctl_s[S].valid) begin
      clamped_d = ctl_s[S].clamp;
      case (ctl_s[S].mode)
        MODE_COS:  result_d = round_sat(x_s[S]);
        MODE_SIN:  result_d = round_sat(y_s[S]);
        MODE_BOTH: begin
          result_d     = round_sat(x_s[S]);
          result_aux_d = round_sat(y_s[S]);
        end
        MODE_PASS: result_d = ang_s[S];
        default:   result_d = '0;
      endcase
    end
  end

  // Output register; holds (including done) while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q     <= '0;
      result_aux_q <= '0;
      clamped_q    <= 1'b0;
      done_q       <= 1'b0;
    end else if (clk_en) begin
      result_q     <= result_d;
      result_aux_q <= result_aux_d;
      clamped_q    <= clamped_d;
      done_q       <= done_d;
    end
  end

  assign result     = result_q;
  assign result_aux = result_aux_q;
  assign clamped    = clamped_q;
  assign done       = done_q;

endmodule
